// File: rtl/xsvi_to_axis_bridge_pkg.sv
// Shared types and constants for the XSVI to AXI4-Stream video bridge.
package xsvi_to_axis_bridge_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_FIFO_AW    = 4;

    // FIFO entry layout for the default data width: {tuser, tlast, tdata}
    localparam int unsigned TLAST_BIT = DEF_DATA_WIDTH;
    localparam int unsigned TUSER_BIT = DEF_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_WAIT_SOF   = 2'd1,
        ST_ACTIVE     = 2'd2
    } state_t;

    function automatic int unsigned tlast_bit(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned tuser_bit(input int unsigned dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/xsvi_to_axis_bridge_if.sv
// AXI4-Stream video bus: master is the bridge, slave is the downstream sink.
interface xsvi_to_axis_bridge_if
    import xsvi_to_axis_bridge_pkg::*;
#(
    parameter int unsigned DW = DEF_DATA_WIDTH
) ();

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/xsvi_to_axis_bridge_video_sync_fifo.sv
// Single-clock show-ahead FIFO; a write into a full FIFO is accepted only alongside a read.
module video_sync_fifo #(
    parameter int unsigned W     = 34,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_valid,
    output logic         o_full_c
);

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_valid;
    logic          w_wr;
    logic          w_rd;

    assign o_full_c  = (r_count == L_FULL);
    assign w_rd      = i_rd_en && r_valid;
    assign w_wr      = i_wr_en && (!o_full_c || w_rd);
    assign o_valid   = r_valid;
    assign o_rd_data = r_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/xsvi_to_axis_bridge.sv
// Re-packs an XSVI pixel stream as AXI4-Stream video (tuser = SOF, tlast = EOL),
// dropping the remainder of a frame on FIFO overflow and relocking on the next vsync.
module xsvi_to_axis_bridge
    import xsvi_to_axis_bridge_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned C_FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned C_FIFO_AW    = DEF_FIFO_AW
) (
    input  logic                    pix_clk,
    input  logic                    areset_n,
    input  logic                    enable,
    input  logic                    ovf_clear,
    input  logic [C_DATA_WIDTH-1:0] pix_data,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    vde,
    xsvi_to_axis_bridge_if.master   m_axis,
    output logic                    overflow,
    output logic                    locked
);

    localparam int unsigned L_EW      = C_DATA_WIDTH + 2;
    localparam int unsigned L_TLAST_B = tlast_bit(C_DATA_WIDTH);
    localparam int unsigned L_TUSER_B = tuser_bit(C_DATA_WIDTH);

    state_t                  r_state;
    logic                    r_vsync_d;
    logic                    r_sof_pending;
    logic                    r_hold_vld;
    logic                    r_hold_sof;
    logic [C_DATA_WIDTH-1:0] r_hold_data;
    logic                    r_overflow;
    logic                    r_locked;

    logic                    w_vsync_rise;
    logic                    w_vsync_fall;
    logic                    w_wr_req;
    logic                    w_rd_hs;
    logic                    w_ovf_evt;
    logic                    w_wr_en;
    logic                    w_full;
    logic                    w_valid;
    logic [L_EW-1:0]         w_wr_data;
    logic [L_EW-1:0]         w_rd_data;
    logic                    w_unused;

    // hsync carries no information the bridge needs beyond vde.
    assign w_unused = hsync;

    assign w_vsync_rise = vsync && !r_vsync_d;
    assign w_vsync_fall = !vsync && r_vsync_d;
    assign w_rd_hs      = w_valid && m_axis.tready;
    assign w_wr_req     = enable && (r_state == ST_ACTIVE) && r_hold_vld;
    assign w_ovf_evt    = w_wr_req && w_full && !w_rd_hs;
    assign w_wr_en      = w_wr_req && !w_ovf_evt;

    // Held pixel closes the line when the current cycle has no video.
    always_comb begin
        w_wr_data                     = '0;
        w_wr_data[C_DATA_WIDTH-1:0]   = r_hold_data;
        w_wr_data[L_TLAST_B]          = !vde;
        w_wr_data[L_TUSER_B]          = r_hold_sof;
    end

    always_ff @(posedge pix_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state       <= ST_WAIT_VSYNC;
            r_vsync_d     <= 1'b0;
            r_sof_pending <= 1'b0;
            r_hold_vld    <= 1'b0;
            r_hold_sof    <= 1'b0;
            r_hold_data   <= '0;
            r_overflow    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_vsync_d <= vsync;

            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end

            if (!enable) begin
                r_state       <= ST_WAIT_VSYNC;
                r_hold_vld    <= 1'b0;
                r_sof_pending <= 1'b0;
                r_locked      <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_VSYNC: begin
                        r_hold_vld <= 1'b0;
                        if (vsync) r_state <= ST_WAIT_SOF;
                    end
                    ST_WAIT_SOF: begin
                        if (w_vsync_fall) begin
                            r_state       <= ST_ACTIVE;
                            r_sof_pending <= 1'b1;
                            r_locked      <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_ovf_evt) begin
                            r_state       <= ST_WAIT_VSYNC;
                            r_hold_vld    <= 1'b0;
                            r_sof_pending <= 1'b0;
                            r_locked      <= 1'b0;
                        end else begin
                            if (vde) begin
                                r_hold_data <= pix_data;
                                r_hold_sof  <= r_sof_pending;
                                r_hold_vld  <= 1'b1;
                            end else begin
                                r_hold_vld  <= 1'b0;
                            end
                            // A new frame start outranks consuming the pending flag.
                            if (w_vsync_rise) begin
                                r_sof_pending <= 1'b1;
                            end else if (vde) begin
                                r_sof_pending <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_WAIT_VSYNC;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    video_sync_fifo #(
        .W     (L_EW),
        .DEPTH (C_FIFO_DEPTH),
        .AW    (C_FIFO_AW)
    ) u_fifo (
        .clk       (pix_clk),
        .rst_n     (areset_n),
        .i_flush   (!enable),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (m_axis.tready),
        .o_rd_data (w_rd_data),
        .o_valid   (w_valid),
        .o_full_c  (w_full)
    );

    assign m_axis.tdata  = w_rd_data[C_DATA_WIDTH-1:0];
    assign m_axis.tlast  = w_rd_data[L_TLAST_B];
    assign m_axis.tuser  = w_rd_data[L_TUSER_B];
    assign m_axis.tvalid = w_valid;
    assign overflow      = r_overflow;
    assign locked        = r_locked;

endmodule

// File: tb/tb_xsvi_to_axis_bridge.sv
// Scoreboard bench for xsvi_to_axis_bridge: 12x6 timing with an 8x4 active window.
module tb_xsvi_to_axis_bridge;
    import xsvi_to_axis_bridge_pkg::*;

    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int HT = 12;
    localparam int VT = 6;

    logic          pix_clk;
    logic          areset_n;
    logic          enable;
    logic          ovf_clear;
    logic [DW-1:0] pix_data;
    logic          hsync;
    logic          vsync;
    logic          vde;
    logic          overflow;
    logic          locked;

    xsvi_to_axis_bridge_if #(.DW(DW)) m_axis ();

    xsvi_to_axis_bridge #(
        .C_DATA_WIDTH (DW),
        .C_FIFO_DEPTH (DEF_FIFO_DEPTH),
        .C_FIFO_AW    (DEF_FIFO_AW)
    ) dut (
        .pix_clk   (pix_clk),
        .areset_n  (areset_n),
        .enable    (enable),
        .ovf_clear (ovf_clear),
        .pix_data  (pix_data),
        .hsync     (hsync),
        .vsync     (vsync),
        .vde       (vde),
        .m_axis    (m_axis),
        .overflow  (overflow),
        .locked    (locked)
    );

    int n_checks = 0;
    int n_errors = 0;
    int frame_no = 0;
    int h_beg = 2;
    int h_end = 10;
    int v_beg = 1;
    int v_end = 5;
    logic [63:0] sb [$];

    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Every handshake pops one expected beat.
    always @(negedge pix_clk) begin
        if (areset_n && m_axis.tvalid && m_axis.tready) begin
            if (sb.size() == 0) begin
                check_val("sb_depth_at_beat", 64'(sb.size()), 64'd1);
            end else begin
                check_val("beat", 64'({m_axis.tuser, m_axis.tlast, m_axis.tdata}), sb.pop_front());
            end
        end
    end

    task automatic run_frame(input bit push_en, input int push_limit, input int rdy_off,
                             input int en_line, input int rst_line,
                             input bit exp_lock, input bit exp_ovf);
        int idx = 0;
        int pushed = 0;
        bit push_ok = push_en;
        bit act;
        logic [TUSER_BIT:0] e;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(posedge pix_clk);
                #1;
                if (v == rst_line && h == 5) begin
                    check_val("pre_rst_tvalid", 64'(m_axis.tvalid), 64'd1);
                    check_val("pre_rst_locked", 64'(locked), 64'd1);
                    areset_n = 1'b0;
                    #1;
                    check_val("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
                    check_val("rst_locked", 64'(locked), 64'd0);
                    check_val("rst_overflow", 64'(overflow), 64'd0);
                    sb.delete();
                    push_ok = 1'b0;
                end
                if (v == rst_line && h == 9) areset_n = 1'b1;
                if (en_line >= 0) enable = (v >= en_line);
                act = (v >= v_beg) && (v < v_end) && (h >= h_beg) && (h < h_end);
                vsync = (v == 0);
                hsync = (h == 0);
                vde = act;
                pix_data = act ? DW'(frame_no * 256 + idx) : '0;
                m_axis.tready = !((v >= v_beg) && (v < v_beg + rdy_off));
                if (act) begin
                    if (push_ok && pushed < push_limit) begin
                        e = '0;
                        e[DW-1:0]  = pix_data;
                        e[TLAST_BIT] = (h == h_end - 1);
                        e[TUSER_BIT] = (pushed == 0);
                        sb.push_back(64'(e));
                        pushed++;
                    end
                    idx++;
                end
            end
        end
        check_val("frame_locked", 64'(locked), 64'(exp_lock));
        check_val("frame_overflow", 64'(overflow), 64'(exp_ovf));
        check_val("frame_sb_drained", 64'(sb.size()), 64'd0);
        frame_no++;
    endtask

    initial begin
        areset_n = 1'b0;
        enable = 1'b1;
        ovf_clear = 1'b0;
        pix_data = '0;
        hsync = 1'b0;
        vsync = 1'b0;
        vde = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) @(posedge pix_clk);
        #1;
        check_val("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
        check_val("reset_locked", 64'(locked), 64'd0);
        check_val("reset_overflow", 64'(overflow), 64'd0);
        areset_n = 1'b1;
        repeat (2) @(posedge pix_clk);

        // Basic 8x4 frames
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);
        // Enable rises mid-frame: that partial frame is never emitted
        run_frame(1'b0, 0, 0, 2, -1, 1'b0, 1'b0);
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);
        // Backpressure for one line fits in the FIFO
        run_frame(1'b1, 1000, 1, -1, -1, 1'b1, 1'b0);
        // Three lines of backpressure overflow on pixel 17
        run_frame(1'b1, 16, 3, -1, -1, 1'b0, 1'b1);
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b1);

        @(posedge pix_clk); #1;
        ovf_clear = 1'b1;
        @(posedge pix_clk); #1;
        ovf_clear = 1'b0;
        check_val("ovf_cleared", 64'(overflow), 64'd0);

        // Overflow again, then an asynchronous reset mid-line
        run_frame(1'b1, 16, 3, -1, -1, 1'b0, 1'b1);
        run_frame(1'b1, 1000, 0, -1, 2, 1'b0, 1'b0);
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);

        // One-pixel-wide active region
        h_beg = 2;
        h_end = 3;
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);
        run_frame(1'b1, 1000, 0, -1, -1, 1'b1, 1'b0);

        repeat (4) @(posedge pix_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
